led_pattern_sequencer: RTL

//  Autonomous sequencer for the 8-bit LED PIO in the NIOS2 QSYS system. The CPU loads a pattern table and a

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_seq_step_timer.sv | 36 +++
 rtl/led_pattern_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - register map, bit indices and FSM encoding for the LED pattern sequencer
package led_seq_pkg;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_PERIOD  = 4'd2;
  localparam logic [3:0] REG_LENGTH  = 4'd3;
  localparam logic [3:0] REG_PATTERN = 4'd8;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int CTRL_IRQ_ENA = 2;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_IDX_LSB = 4;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } seq_state_e;

endpackage

// File: rtl/led_seq_step_timer.sv
// rtl/led_seq_step_timer.sv - loadable down-counter timing the gap between pattern writes
module led_seq_step_timer
  import led_seq_pkg::*;
#(
  parameter int PER_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [PER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - Avalon-MM LED pattern sequencer writing a pattern table to a PIO
// Optional LED_SEQ_IRQ_EN adds the irq output and a writable CTRL.IRQ_ENA bit.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LED_W = 8,
  parameter int PER_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef LED_SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  seq_state_e       state_q, state_d;
  logic             run_q, run_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [3:0]       length_q, length_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [LED_W-1:0] wdata_q, wdata_d;
  logic [LED_W-1:0] pattern_q [DEPTH];
  logic [LED_W-1:0] pattern_d [DEPTH];

  logic             wr_en;
  logic [3:0]       len_eff;
  logic             is_last;
  logic [IDX_W-1:0] next_idx;
  logic [LED_W-1:0] next_pat;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [PER_W-1:0] tmr_load_val;
  logic             irq_ena_rd;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Out-of-range LENGTH folds to the full table.
  always_comb begin
    len_eff = length_q;
    if ((length_q == 4'd0) || (length_q > 4'(DEPTH))) begin
      len_eff = 4'(DEPTH);
    end
  end

  assign is_last      = ({1'b0, index_q} == (len_eff - 4'd1));
  assign next_idx     = is_last ? '0 : index_q + IDX_W'(1);
  assign tmr_load_val = (period_q == '0) ? '0 : period_q - PER_W'(1);

  always_comb begin
    next_pat = pattern_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (next_idx == IDX_W'(i)) begin
        next_pat = pattern_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    loop_d    = loop_q;
    done_d    = done_q;
    period_d  = period_q;
    length_d  = length_q;
    pattern_d = pattern_q;
    index_d   = index_q;
    wdata_d   = wdata_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    if (wr_en) begin
      case (address)
        REG_CTRL: begin
          run_d  = writedata[CTRL_RUN];
          loop_d = writedata[CTRL_LOOP];
        end
        REG_STATUS: if (writedata[STATUS_DONE]) done_d = 1'b0;
        REG_PERIOD: period_d = writedata[PER_W-1:0];
        REG_LENGTH: length_d = writedata[3:0];
        default: ;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (address == (REG_PATTERN + 4'(i))) begin
          pattern_d[i] = writedata[LED_W-1:0];
        end
      end
    end

    // FSM updates come after CPU writes so a hardware DONE set / RUN clear wins.
    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_ISSUE;
          index_d = '0;
          wdata_d = pattern_q[0];
        end
      end
      ST_ISSUE: begin
        if (!m_waitrequest) begin
          if (run_q) begin
            state_d  = ST_WAIT;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!run_q) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          if (is_last && !loop_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            run_d   = 1'b0;
          end else begin
            state_d = ST_ISSUE;
            index_d = next_idx;
            wdata_d = next_pat;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      index_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pattern_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      loop_q    <= loop_d;
      done_q    <= done_d;
      period_q  <= period_d;
      length_q  <= length_d;
      index_q   <= index_d;
      wdata_q   <= wdata_d;
      pattern_q <= pattern_d;
    end
  end

  led_seq_step_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef LED_SEQ_IRQ_EN
  logic irq_ena_q, irq_ena_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_ena_d = irq_ena_q;
    if (wr_en && (address == REG_CTRL)) begin
      irq_ena_d = writedata[CTRL_IRQ_ENA];
    end
    irq_d = done_q & irq_ena_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_ena_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_ena_q <= irq_ena_d;
      irq_q     <= irq_d;
    end
  end

  assign irq        = irq_q;
  assign irq_ena_rd = irq_ena_q;
`else
  assign irq_ena_rd = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_RUN]     = run_q;
        readdata[CTRL_LOOP]    = loop_q;
        readdata[CTRL_IRQ_ENA] = irq_ena_rd;
      end
      REG_STATUS: begin
        readdata[STATUS_BUSY]                 = (state_q != ST_IDLE);
        readdata[STATUS_DONE]                 = done_q;
        readdata[STATUS_IDX_LSB +: IDX_W]     = index_q;
      end
      REG_PERIOD: readdata[PER_W-1:0] = period_q;
      REG_LENGTH: readdata[3:0]       = length_q;
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (address == (REG_PATTERN + 4'(i))) begin
            readdata[LED_W-1:0] = pattern_q[i];
          end
        end
      end
    endcase
  end

  assign m_address   = 2'd0;
  assign m_write     = (state_q == ST_ISSUE);
  assign m_writedata = {{(32-LED_W){1'b0}}, wdata_q};

endmodule
